// File: rtl/bsg_wormhole_test_responder_if.sv
// bsg_wormhole_test_responder_if: request and response flit channels of the test responder
interface bsg_wormhole_test_responder_if #(parameter flit_width_p = "inv") ();
  logic                    v_i;
  logic [flit_width_p-1:0] data_i;
  logic                    ready_and_o;
  logic                    v_o;
  logic [flit_width_p-1:0] data_o;
  logic                    ready_and_i;
  modport slave (input v_i, data_i, ready_and_i, output ready_and_o, v_o, data_o);
  modport master (output v_i, data_i, ready_and_i, input ready_and_o, v_o, data_o);
endinterface

// File: rtl/bsg_wormhole_test_responder.sv
// bsg_wormhole_test_responder: echoes wormhole packets addressed to this node back to their source; optional BSG_WORMHOLE_TEST_RESPONDER_STALL_EN adds LFSR input stalls
module bsg_wormhole_test_responder #(
  parameter flit_width_p = "inv",
  parameter cord_width_p = "inv",
  parameter len_width_p  = "inv"
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [cord_width_p-1:0]  my_cord_i,
  bsg_wormhole_test_responder_if.slave io,
  output logic [31:0]              packet_count_o,
  output logic                     error_o
);
  localparam int hi_lp = 2*cord_width_p + len_width_p;
  typedef enum logic [1:0] {IDLE, FWD, DROP} state_e;
  state_e r_state, w_state_n;
  logic [len_width_p-1:0] r_cnt, w_cnt_n;
  logic r_v, r_last, r_err;
  logic [flit_width_p-1:0] r_data;
  logic [31:0] r_count;
  logic [cord_width_p-1:0] w_cord, w_src;
  logic [len_width_p-1:0] w_len;
  logic w_hit, w_ready, w_acc, w_emit, w_last;
  logic [flit_width_p-1:0] w_resp, w_out;
  assign w_cord = io.data_i[cord_width_p-1:0];
  assign w_len  = io.data_i[cord_width_p+len_width_p-1:cord_width_p];
  assign w_src  = io.data_i[hi_lp-1:cord_width_p+len_width_p];
  assign w_hit  = w_cord == my_cord_i;
  assign w_resp = {io.data_i[flit_width_p-1:hi_lp], my_cord_i, w_len, w_src};
`ifdef BSG_WORMHOLE_TEST_RESPONDER_STALL_EN
  logic [7:0] r_lfsr;
  // maximal-length LFSR (taps 8,6,5,4) gating input acceptance
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) r_lfsr <= 8'h01;
    else r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_ready = ((r_state == DROP) | ~r_v | io.ready_and_i) & r_lfsr[0];
`else
  assign w_ready = (r_state == DROP) | ~r_v | io.ready_and_i;
`endif
  assign w_acc  = io.v_i & w_ready;
  assign w_emit = w_acc & (((r_state == IDLE) & w_hit) | (r_state == FWD));
  assign w_last = (r_state == IDLE) ? (w_len == '0) : (r_cnt == len_width_p'(1));
  assign w_out  = (r_state == IDLE) ? w_resp : io.data_i;
  // state and remaining-body-flit counter registers
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  // header loads the length and picks echo or discard; the last body flit returns to IDLE
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (w_acc && r_state == IDLE) begin
      w_cnt_n   = w_len;
      w_state_n = (w_len == '0) ? IDLE : (w_hit ? FWD : DROP);
    end else if (w_acc) begin
      w_cnt_n   = r_cnt - len_width_p'(1);
      w_state_n = (r_cnt == len_width_p'(1)) ? IDLE : r_state;
    end
  end
  // single output stage holding the flit until consumed, plus sticky error and packet counter
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      r_v     <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_emit) begin
        r_v    <= 1'b1;
        r_data <= w_out;
        r_last <= w_last;
      end else if (io.ready_and_i) r_v <= 1'b0;
      if (w_acc && r_state == IDLE && !w_hit) r_err <= 1'b1;
      if (r_v && io.ready_and_i && r_last) r_count <= r_count + 32'd1;
    end
  assign io.ready_and_o = w_ready;
  assign io.v_o         = r_v;
  assign io.data_o      = r_data;
  assign packet_count_o = r_count;
  assign error_o        = r_err;
endmodule

// File: tb/tb_bsg_wormhole_test_responder.sv
// tb_bsg_wormhole_test_responder: directed and random packets checked against a packet-level model
module tb_bsg_wormhole_test_responder;
  localparam int FW = 32, CW = 5, LW = 3;
  logic clk = 1'b0;
  logic reset_i;
  logic [CW-1:0] my = 5'd3;
  logic [31:0] cnt;
  logic err;
  always #5 clk = ~clk;
  bsg_wormhole_test_responder_if #(.flit_width_p(FW)) bus ();
  bsg_wormhole_test_responder #(.flit_width_p(FW), .cord_width_p(CW), .len_width_p(LW)) dut (
    .clk_i(clk), .reset_i(reset_i), .my_cord_i(my), .io(bus), .packet_count_o(cnt), .error_o(err));
  logic [FW:0] q[$];
  int rem = 0;
  bit fwd = 1'b0;
  bit e_err = 1'b0;
  logic [31:0] e_cnt = '0;
  int checks = 0, errors = 0;
  int rdy_pct = 100, stall_left = 0;
  bit gap_en = 1'b0;
  logic [31:0] base;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [FW-1:0] d);
    logic [CW-1:0] c, s;
    logic [LW-1:0] l;
    if (rem == 0) begin
      c = d[CW-1:0];
      l = d[CW+LW-1:CW];
      s = d[2*CW+LW-1:CW+LW];
      fwd = (c == my);
      if (fwd) q.push_back({(l == 3'd0), d[FW-1:2*CW+LW], my, l, s});
      else e_err = 1'b1;
      rem = int'(l);
    end else begin
      if (fwd) q.push_back({(rem == 1), d});
      rem--;
    end
  endtask
  task automatic cyc(output bit acc);
    bit drop, exp_rdy;
    @(negedge clk);
    drop = (rem > 0) && !fwd;
    exp_rdy = (q.size() == 0) || bus.ready_and_i || drop;
    chk("v_o", {31'd0, bus.v_o}, {31'd0, q.size() > 0});
    if (bus.v_o && q.size() > 0) chk("data_o", bus.data_o, q[0][FW-1:0]);
    chk("ready_and_o", {31'd0, bus.ready_and_o}, {31'd0, exp_rdy});
    chk("error_o", {31'd0, err}, {31'd0, e_err});
    chk("packet_count_o", cnt, e_cnt);
    if (bus.ready_and_i && q.size() > 0) begin
      if (q[0][FW]) e_cnt++;
      void'(q.pop_front());
    end
    acc = bus.v_i && exp_rdy;
    if (acc) model(bus.data_i);
    @(posedge clk);
    #1;
    if (stall_left > 0) begin
      bus.ready_and_i = 1'b0;
      stall_left--;
    end else bus.ready_and_i = ($urandom_range(0, 99) < rdy_pct);
  endtask
  task automatic idle(input int n);
    bit a;
    bus.v_i = 1'b0;
    repeat (n) cyc(a);
  endtask
  task automatic send(input logic [FW-1:0] d);
    bit a = 1'b0;
    if (gap_en && $urandom_range(0, 3) == 0) idle(1);
    bus.v_i = 1'b1;
    bus.data_i = d;
    for (int i = 0; i < 200 && !a; i++) cyc(a);
    if (!a) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout observed=stuck expected=accepted");
    end
  endtask
  task automatic send_pkt(input logic [CW-1:0] c, input logic [LW-1:0] l);
    logic [FW-1:0] pay;
    pay = $urandom;
    send({pay[FW-2*CW-LW-1:0], CW'($urandom), l, c});
    for (int i = 0; i < int'(l); i++) send($urandom);
  endtask
  task automatic do_reset();
    reset_i = 1'b1;
    bus.v_i = 1'b0;
    #1;
    chk("reset_v_o", {31'd0, bus.v_o}, 32'd0);
    chk("reset_error_o", {31'd0, err}, 32'd0);
    chk("reset_count", cnt, 32'd0);
    q.delete();
    rem = 0;
    fwd = 1'b0;
    e_err = 1'b0;
    e_cnt = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_i = 1'b0;
  endtask
  initial begin
    bus.v_i = 1'b0;
    bus.data_i = '0;
    bus.ready_and_i = 1'b1;
    reset_i = 1'b0;
    #2;
    do_reset();
    chk("reset_ready", {31'd0, bus.ready_and_o}, 32'd1);
    send(32'h0000_0A43);
    send(32'h0000_0011);
    send(32'h0000_0022);
    idle(3);
    chk("basic_count", cnt, 32'd1);
    send_pkt(5'd4, 3'd1);
    idle(2);
    chk("misroute_error", {31'd0, err}, 32'd1);
    chk("misroute_count", cnt, 32'd1);
    send_pkt(5'd3, 3'd0);
    send_pkt(5'd3, 3'd4);
    send(32'hABCD_0001);
    send(32'hABCD_0002);
    stall_left = 5;
    send(32'hABCD_0003);
    send(32'hABCD_0004);
    idle(2);
    base = cnt;
    repeat (4) send_pkt(5'd3, 3'd0);
    idle(2);
    chk("hdr_only_count", cnt, base + 32'd4);
    send_pkt(5'd3, 3'd0);
    send(32'h0000_0063);
    send(32'h0000_0055);
    #2;
    do_reset();
    send_pkt(5'd3, 3'd2);
    idle(2);
    chk("post_reset_count", cnt, 32'd1);
    gap_en = 1'b1;
    rdy_pct = 70;
    for (int p = 0; p < 40; p++) send_pkt(($urandom_range(0, 2) != 0) ? my : CW'($urandom), LW'($urandom));
    idle(4);
    gap_en = 1'b0;
    rdy_pct = 100;
    force dut.r_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_count;
    e_cnt = 32'hFFFF_FFFE;
    send_pkt(5'd3, 3'd0);
    send_pkt(5'd3, 3'd0);
    idle(3);
    chk("wrap_count", cnt, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
